// File: rtl/counter_threshold_classifier_multi.sv
// Per-link fault classifier: NUM_CH independent channels, each counting
// faulty and healthy packet reports and classifying its link as
// HEALTHY / INTERMITTENT / FAULTY. Repeated DET events without an intervening
// NET escalate a channel to FAULTY, where it stays until clear_faulty.
// Event pulses and any_faulty are registered.
module counter_threshold_classifier_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int HEALTHY_TH  = 4,
    parameter int FAULTY_TH   = 4,
    parameter int MAX_STRIKES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     faulty_packet,
    input  logic [NUM_CH-1:0]     healthy_packet,
    input  logic [NUM_CH-1:0]     clear_faulty,
    output logic [3*NUM_CH-1:0]   state_o,
    output logic [NUM_CH-1:0]     healthy_pulse,
    output logic [NUM_CH-1:0]     intermittent_pulse,
    output logic [NUM_CH-1:0]     faulty_pulse,
    output logic                  any_faulty
);

    localparam int STK_W = $clog2(MAX_STRIKES + 1);

    typedef enum logic [2:0] {
        ST_HEALTHY = 3'b001,
        ST_INTERM  = 3'b010,
        ST_FAULTY  = 3'b100
    } state_t;

    // Per-channel "will be FAULTY after this edge", used to register any_faulty
    // in the same cycle as the state bits.
    logic [NUM_CH-1:0] next_faulty_s;
    logic              any_faulty_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state_r;
        logic [CNT_W-1:0] hcnt_r;
        logic [CNT_W-1:0] fcnt_r;
        logic [STK_W-1:0] strikes_r;
        logic             hpulse_r;
        logic             ipulse_r;
        logic             fpulse_r;

        logic             net_s;
        logic             det_s;
        logic [STK_W-1:0] strikes_inc_s;
        logic             last_strike_s;
        logic [CNT_W-1:0] hcnt_next_s;
        logic [CNT_W-1:0] fcnt_next_s;
        logic             nf_s;

        // Threshold events, strike arithmetic and counter next values.
        always_comb begin
            net_s         = (hcnt_r == CNT_W'(HEALTHY_TH));
            det_s         = (fcnt_r == CNT_W'(FAULTY_TH));
            strikes_inc_s = strikes_r + STK_W'(1);
            last_strike_s = (strikes_inc_s == STK_W'(MAX_STRIKES));
            if (net_s || det_s) begin
                // Restart both counts, keeping any report of this cycle.
                hcnt_next_s = CNT_W'(healthy_packet[c]);
                fcnt_next_s = CNT_W'(faulty_packet[c]);
            end else begin
                hcnt_next_s = hcnt_r + CNT_W'(healthy_packet[c]);
                fcnt_next_s = fcnt_r + CNT_W'(faulty_packet[c]);
            end
        end

        // Predict whether the channel sits in FAULTY after the coming edge.
        always_comb begin
            nf_s = 1'b0;
            case (state_r)
                ST_FAULTY: nf_s = ~clear_faulty[c];
                ST_INTERM: nf_s = ~net_s & det_s & last_strike_s;
                default:   nf_s = 1'b0;
            endcase
        end

        // Channel FSM with counters, strikes and registered event pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_r   <= ST_HEALTHY;
                hcnt_r    <= '0;
                fcnt_r    <= '0;
                strikes_r <= '0;
                hpulse_r  <= 1'b0;
                ipulse_r  <= 1'b0;
                fpulse_r  <= 1'b0;
            end else begin
                hpulse_r <= 1'b0;
                ipulse_r <= 1'b0;
                fpulse_r <= 1'b0;
                case (state_r)
                    ST_HEALTHY: begin
                        hcnt_r <= hcnt_next_s;
                        fcnt_r <= fcnt_next_s;
                        if (net_s) begin
                            strikes_r <= '0;
                        end else if (det_s) begin
                            state_r   <= ST_INTERM;
                            strikes_r <= STK_W'(1);
                            ipulse_r  <= 1'b1;
                        end
                    end
                    ST_INTERM: begin
                        hcnt_r <= hcnt_next_s;
                        fcnt_r <= fcnt_next_s;
                        if (net_s) begin
                            // NET outranks a coincident DET.
                            state_r   <= ST_HEALTHY;
                            strikes_r <= '0;
                            hpulse_r  <= 1'b1;
                        end else if (det_s) begin
                            strikes_r <= strikes_inc_s;
                            if (last_strike_s) begin
                                state_r  <= ST_FAULTY;
                                fpulse_r <= 1'b1;
                            end
                        end
                    end
                    ST_FAULTY: begin
                        // Reports are ignored until software clears the link.
                        hcnt_r <= '0;
                        fcnt_r <= '0;
                        if (clear_faulty[c]) begin
                            state_r   <= ST_HEALTHY;
                            strikes_r <= '0;
                        end
                    end
                    default: begin
                        // Corrupted encoding: recover to HEALTHY and flag it.
                        state_r   <= ST_HEALTHY;
                        hcnt_r    <= '0;
                        fcnt_r    <= '0;
                        strikes_r <= '0;
                        hpulse_r  <= 1'b1;
                    end
                endcase
            end
        end

        assign next_faulty_s[c]      = nf_s;
        assign state_o[3*c +: 3]     = state_r;
        assign healthy_pulse[c]      = hpulse_r;
        assign intermittent_pulse[c] = ipulse_r;
        assign faulty_pulse[c]       = fpulse_r;
    end

    // Global fault flag, registered alongside the per-channel state bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_faulty_r <= 1'b0;
        end else begin
            any_faulty_r <= |next_faulty_s;
        end
    end

    assign any_faulty = any_faulty_r;

endmodule

// File: tb/tb_counter_threshold_classifier_multi.sv
// Testbench for counter_threshold_classifier_multi: directed scenarios plus
// randomized traffic, every cycle compared against a behavioural model.
module tb_counter_threshold_classifier_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int HTH    = 4;
    localparam int FTH    = 4;
    localparam int MAXS   = 2;
    localparam int VW     = 6 * NUM_CH + 1;

    logic                clk;
    logic                reset;
    logic [NUM_CH-1:0]   faulty_packet;
    logic [NUM_CH-1:0]   healthy_packet;
    logic [NUM_CH-1:0]   clear_faulty;
    logic [3*NUM_CH-1:0] state_o;
    logic [NUM_CH-1:0]   healthy_pulse;
    logic [NUM_CH-1:0]   intermittent_pulse;
    logic [NUM_CH-1:0]   faulty_pulse;
    logic                any_faulty;
    logic [VW-1:0]       vec_s;

    int n_vec;
    int n_err;

    // Model: state 0=HEALTHY 1=INTERMITTENT 2=FAULTY
    int m_h  [NUM_CH];
    int m_f  [NUM_CH];
    int m_s  [NUM_CH];
    int m_st [NUM_CH];
    bit m_hp [NUM_CH];
    bit m_ip [NUM_CH];
    bit m_fp [NUM_CH];

    counter_threshold_classifier_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .HEALTHY_TH(HTH),
        .FAULTY_TH(FTH), .MAX_STRIKES(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .faulty_packet(faulty_packet), .healthy_packet(healthy_packet),
        .clear_faulty(clear_faulty), .state_o(state_o),
        .healthy_pulse(healthy_pulse), .intermittent_pulse(intermittent_pulse),
        .faulty_pulse(faulty_pulse), .any_faulty(any_faulty)
    );

    assign vec_s = {state_o, healthy_pulse, intermittent_pulse, faulty_pulse, any_faulty};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_h[c] = 0; m_f[c] = 0; m_s[c] = 0; m_st[c] = 0;
            m_hp[c] = 1'b0; m_ip[c] = 1'b0; m_fp[c] = 1'b0;
        end
    endfunction

    function automatic void model_step(logic [NUM_CH-1:0] f, logic [NUM_CH-1:0] h,
                                       logic [NUM_CH-1:0] cl);
        for (int c = 0; c < NUM_CH; c++) begin
            bit net = (m_h[c] == HTH);
            bit det = (m_f[c] == FTH);
            m_hp[c] = 1'b0; m_ip[c] = 1'b0; m_fp[c] = 1'b0;
            if (m_st[c] == 2) begin
                m_h[c] = 0; m_f[c] = 0;
                if (cl[c]) begin m_st[c] = 0; m_s[c] = 0; end
            end else begin
                if (m_st[c] == 0) begin
                    if (net) m_s[c] = 0;
                    else if (det) begin m_st[c] = 1; m_s[c] = 1; m_ip[c] = 1'b1; end
                end else begin
                    if (net) begin m_st[c] = 0; m_s[c] = 0; m_hp[c] = 1'b1; end
                    else if (det) begin
                        m_s[c] = m_s[c] + 1;
                        if (m_s[c] == MAXS) begin m_st[c] = 2; m_fp[c] = 1'b1; end
                    end
                end
                if (net || det) begin
                    m_h[c] = int'(h[c]); m_f[c] = int'(f[c]);
                end else begin
                    m_h[c] = m_h[c] + int'(h[c]); m_f[c] = m_f[c] + int'(f[c]);
                end
            end
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [3*NUM_CH-1:0] st;
        logic [NUM_CH-1:0]   hp, ip, fp;
        logic                af;
        af = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            st[3*c +: 3] = 3'(1 << m_st[c]);
            hp[c] = m_hp[c]; ip[c] = m_ip[c]; fp[c] = m_fp[c];
            if (m_st[c] == 2) af = 1'b1;
        end
        return {st, hp, ip, fp, af};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1ns after it.
    task automatic step(input logic [NUM_CH-1:0] f, input logic [NUM_CH-1:0] h,
                        input logic [NUM_CH-1:0] cl);
        @(negedge clk);
        faulty_packet = f; healthy_packet = h; clear_faulty = cl;
        @(posedge clk);
        model_step(f, h, cl);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; faulty_packet = '0; healthy_packet = '0; clear_faulty = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (vec_s !== {{NUM_CH{3'b001}}, {(3*NUM_CH+1){1'b0}}}) begin
            n_err++; $display("FAIL reset_state: got %h expected %h", vec_s, exp_vec());
        end
        reset = 1'b1;
    endtask

    task automatic test_ch0_intermittent();
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 4'b0000, 4'b0000);
            n_vec++;
            if (vec_s !== exp_vec()) begin
                n_err++; $display("FAIL ch0_count e%0d: got %h expected %h", i + 1, vec_s, exp_vec());
            end
        end
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (intermittent_pulse !== 4'b0001 || state_o !== 12'b001_001_001_010) begin
            n_err++; $display("FAIL ch0_interm: got %h/%h expected 1/%h", intermittent_pulse, state_o, 12'b001_001_001_010);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (vec_s !== exp_vec()) begin
            n_err++; $display("FAIL ch0_interm_pulse_end: got %h expected %h", vec_s, exp_vec());
        end
    endtask

    task automatic test_ch0_faulty();
        for (int i = 0; i < 4; i++) step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (faulty_pulse !== 4'b0001 || state_o[2:0] !== 3'b100 || any_faulty !== 1'b1) begin
            n_err++; $display("FAIL ch0_faulty: got fp=%b st=%b af=%b expected 0001 100 1", faulty_pulse, state_o[2:0], any_faulty);
        end
        for (int i = 0; i < 10; i++) begin
            step(4'b0001, 4'b0001, 4'b0000);
            n_vec++;
            if (vec_s !== exp_vec()) begin
                n_err++; $display("FAIL ch0_faulty_hold %0d: got %h expected %h", i, vec_s, exp_vec());
            end
        end
    endtask

    task automatic test_ch1_recover();
        for (int i = 0; i < 4; i++) step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0010, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (healthy_pulse !== 4'b0010 || state_o[5:3] !== 3'b001 || vec_s !== exp_vec()) begin
            n_err++; $display("FAIL ch1_recover: got %h expected %h", vec_s, exp_vec());
        end
        for (int i = 0; i < 4; i++) step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (intermittent_pulse[1] !== 1'b1 || faulty_pulse[1] !== 1'b0 || state_o[5:3] !== 3'b010) begin
            n_err++; $display("FAIL ch1_strikes_cleared: got %h expected %h", vec_s, exp_vec());
        end
    endtask

    task automatic test_ch2_coincident();
        for (int i = 0; i < 4; i++) step(4'b0100, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 4'b0000, 4'b0000);
            step(4'b0000, 4'b0100, 4'b0000);
        end
        step(4'b0100, 4'b0100, 4'b0000);
        step(4'b0100, 4'b0100, 4'b0000);
        n_vec++;
        if (healthy_pulse[2] !== 1'b1 || faulty_pulse[2] !== 1'b0 || state_o[8:6] !== 3'b001) begin
            n_err++; $display("FAIL ch2_net_wins: got %h expected %h", vec_s, exp_vec());
        end
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (intermittent_pulse[2] !== 1'b1 || vec_s !== exp_vec()) begin
            n_err++; $display("FAIL ch2_counts_one: got %h expected %h", vec_s, exp_vec());
        end
    endtask

    task automatic test_clear();
        step(4'b0000, 4'b0000, 4'b0001);
        n_vec++;
        if (state_o[2:0] !== 3'b001 || any_faulty !== 1'b0 || healthy_pulse[0] !== 1'b0) begin
            n_err++; $display("FAIL ch0_clear: got %h expected %h", vec_s, exp_vec());
        end
        step(4'b0000, 4'b0000, 4'b1111);
        n_vec++;
        if (vec_s !== exp_vec()) begin
            n_err++; $display("FAIL clear_no_effect: got %h expected %h", vec_s, exp_vec());
        end
    endtask

    task automatic test_random();
        int bias_f, bias_h;
        logic [NUM_CH-1:0] f, h, cl;
        bias_f = 50; bias_h = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                bias_f = $urandom_range(10, 90);
                bias_h = $urandom_range(10, 90);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                f[c]  = ($urandom_range(0, 99) < bias_f);
                h[c]  = ($urandom_range(0, 99) < bias_h);
                cl[c] = ($urandom_range(0, 19) == 0);
            end
            step(f, h, cl);
            n_vec++;
            if (vec_s !== exp_vec()) begin
                n_err++; $display("FAIL random cyc%0d: got %h expected %h", i, vec_s, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midcount();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) step(4'b1000, 4'b0000, 4'b0000);
            step(4'b0000, 4'b0000, 4'b0000);
        end
        step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0010, 4'b0000, 4'b0000);
        n_vec++;
        if (any_faulty !== 1'b1 || vec_s !== exp_vec()) begin
            n_err++; $display("FAIL pre_reset: got %h expected %h", vec_s, exp_vec());
        end
        #2;
        reset = 1'b0;
        faulty_packet = '0; healthy_packet = '0; clear_faulty = '0;
        model_reset();
        #1;
        n_vec++;
        if (vec_s !== {{NUM_CH{3'b001}}, {(3*NUM_CH+1){1'b0}}}) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", vec_s, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'b0010, 4'b0000, 4'b0000);
            n_vec++;
            if (vec_s !== exp_vec()) begin
                n_err++; $display("FAIL post_reset_count %0d: got %h expected %h", i, vec_s, exp_vec());
            end
        end
        step(4'b0000, 4'b0000, 4'b0000);
        n_vec++;
        if (intermittent_pulse !== 4'b0010 || vec_s !== exp_vec()) begin
            n_err++; $display("FAIL post_reset_interm: got %h expected %h", vec_s, exp_vec());
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ch0_intermittent();
        test_ch0_faulty();
        test_ch1_recover();
        test_ch2_coincident();
        test_clear();
        test_random();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
